// File: rtl/ecc_apb_engine.sv
// Purpose: APB-attached SECDED engine. Queued encode/decode/full-channel jobs run
//          through a 2-state execute FSM.
// Latency: START access cycle T, result and operation_done in cycle T+3. One job per 2 cycles.
// Backpressure: none on APB (PREADY=1). A START into a full FIFO is dropped and sets STATUS.OVF.
// Ports: APB slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY). Result stream
//        (data_out, err_num, operation_done). Level interrupt irq.
module ecc_apb_engine #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 err_num,
  output logic                       operation_done,
  output logic                       irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
  } job_t;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  // XOR of the indices of all set bits in positions 1..31.
  function automatic logic [4:0] syndrome(input logic [31:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 1; i < 32; i++)
      if (v[i[4:0]]) s = s ^ i[4:0];
    return s;
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Data bits land on non-power positions in ascending order, so the narrower
  // codewords are simply a masked prefix of the 32-bit layout.
  function automatic logic [31:0] ecc_encode(input logic [31:0] mask, input logic [31:0] d);
    logic [31:0] cw;
    logic [4:0]  k;
    logic [4:0]  s;
    cw = '0;
    k  = '0;
    for (int i = 3; i < 32; i++)
      if ((i & (i - 1)) != 0) begin
        cw[i[4:0]] = d[k];
        k = k + 5'd1;
      end
    cw = cw & mask;
    // With parity slots still zero, the syndrome is exactly the parity vector.
    s = syndrome(cw);
    cw[1]  = s[0];
    cw[2]  = s[1];
    cw[4]  = s[2];
    cw[8]  = s[3];
    cw[16] = s[4];
    cw = cw & mask;
    cw[0] = ^cw;
    return cw;
  endfunction

  // Returns {err_num, data[25:0]}; input must already be masked to the codeword width.
  function automatic logic [27:0] ecc_decode(input logic [31:0] rx);
    logic [31:0] r;
    logic [4:0]  s;
    logic        p;
    logic [1:0]  err;
    logic [25:0] dat;
    logic [4:0]  k;
    r = rx;
    s = syndrome(r);
    p = ^r;
    if (p) r[s] = ~r[s];
    err = p ? 2'd1 : ((s != 5'd0) ? 2'd2 : 2'd0);
    dat = '0;
    k   = '0;
    for (int i = 3; i < 32; i++)
      if ((i & (i - 1)) != 0) begin
        dat[k] = r[i[4:0]];
        k = k + 5'd1;
      end
    return {err, dat};
  endfunction

  // ---------------- APB decode / registers ----------------
  logic        wr_acc, rd_setup, start_req, cfg_bad, push_vld, pop_vld;
  logic [4:0]  addr;
  logic [1:0]  ctrl_op, cw_width;
  logic        irq_en, done, ovf, cfgerr, busy;
  logic [31:0] data_in, noise, result_q;
  logic [AMBA_WORD-1:0] rd_mux;
  state_t      state, state_nxt;

  logic [PTR_W:0] wr_ptr, rd_ptr, fifo_cnt;
  logic           fifo_full, fifo_empty;
  job_t           fifo_mem [FIFO_DEPTH];
  job_t           job_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^PADDR[AMBA_ADDR_WIDTH-1:5];

  assign addr      = PADDR[4:0];
  assign wr_acc    = PSEL & PENABLE & PWRITE;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign start_req = wr_acc && (addr == 5'h00) && PWDATA[2];
  assign cfg_bad   = (PWDATA[1:0] == 2'b11) || (cw_width == 2'b11);
  // Fullness is judged before any same-cycle pop.
  assign push_vld  = start_req & ~cfg_bad & ~fifo_full;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign busy       = (state != IDLE) | ~fifo_empty;
  assign PREADY     = 1'b1;
  assign irq        = done & irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_op  <= '0;
      irq_en   <= 1'b0;
      cw_width <= '0;
      data_in  <= '0;
      noise    <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      cfgerr   <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (addr)
          5'h00: begin ctrl_op <= PWDATA[1:0]; irq_en <= PWDATA[3]; end
          5'h04: data_in  <= PWDATA[31:0];
          5'h08: cw_width <= PWDATA[1:0];
          5'h0C: noise    <= PWDATA[31:0];
          default: ;
        endcase
      end
      // W1C clear first, hardware set ORed on top so a collision keeps the flag.
      done   <= (done   & ~(wr_acc && addr == 5'h10 && PWDATA[1])) | (state == CALC);
      ovf    <= (ovf    & ~(wr_acc && addr == 5'h10 && PWDATA[2])) | (start_req & ~cfg_bad & fifo_full);
      cfgerr <= (cfgerr & ~(wr_acc && addr == 5'h10 && PWDATA[3])) | (start_req & cfg_bad);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      5'h00: rd_mux = AMBA_WORD'({irq_en, 1'b0, ctrl_op});
      5'h04: rd_mux = AMBA_WORD'(data_in);
      5'h08: rd_mux = AMBA_WORD'(cw_width);
      5'h0C: rd_mux = AMBA_WORD'(noise);
      5'h10: rd_mux = AMBA_WORD'({8'(fifo_cnt), 4'b0, cfgerr, ovf, done, busy});
      5'h14: rd_mux = AMBA_WORD'(result_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          PRDATA <= '0;
    else if (rd_setup) PRDATA <= rd_mux;
  end

  // ---------------- job FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_vld)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{op: PWDATA[1:0], width: cw_width, data: data_in, noise: noise};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      job_q  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld) begin
        rd_ptr <= rd_ptr + 1'b1;
        job_q  <= fifo_mem[rd_ptr[PTR_W-1:0]];
      end
    end
  end

  // ---------------- execute FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = CALC;
      CALC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_vld = (state == IDLE) && !fifo_empty;
  end

  // ---------------- compute / result ----------------
  logic [31:0] calc_mask, calc_enc, calc_res;
  logic [27:0] calc_dec;
  logic [1:0]  calc_err;

  always_comb begin
    calc_mask = width_mask(job_q.width);
    calc_enc  = ecc_encode(calc_mask, job_q.data);
    calc_dec  = '0;
    calc_res  = calc_enc;
    calc_err  = 2'd0;
    case (job_q.op)
      2'b01: begin
        calc_dec = ecc_decode(job_q.data & calc_mask);
        calc_res = {6'b0, calc_dec[25:0]};
        calc_err = calc_dec[27:26];
      end
      2'b10: begin
        calc_dec = ecc_decode(calc_enc ^ (job_q.noise & calc_mask));
        calc_res = {6'b0, calc_dec[25:0]};
        calc_err = calc_dec[27:26];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      err_num        <= '0;
      result_q       <= '0;
      operation_done <= 1'b0;
    end else begin
      operation_done <= (state == CALC);
      if (state == CALC) begin
        data_out <= DATA_WIDTH'(calc_res);
        err_num  <= calc_err;
        result_q <= {calc_err, 4'b0, calc_res[25:0]};
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_engine.sv
module tb_ecc_apb_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [19:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [31:0] data_out;
  logic [1:0]  err_num;
  logic        operation_done;
  logic        irq;

  ecc_apb_engine dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .data_out(data_out), .err_num(err_num), .operation_done(operation_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Strobe monitor: records the cycle number of every operation_done pulse.
  int cyc = 0;
  int strobe_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (operation_done) strobe_cyc.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Called in cycle T+1 (right after the START access); counts cycles to the strobe.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!operation_done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  w;
    logic [31:0] din;
    logic [31:0] noise;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_result;
    int lat, n0, bad_gap;

    vecs[0]  = '{"enc_w0_B",        2'b00, 2'd0, 32'h0000_000B, 32'h0,        32'h0000_00AA, 2'd0};
    vecs[1]  = '{"dec_w0_1err",     2'b01, 2'd0, 32'h0000_008A, 32'h0,        32'h0000_000B, 2'd1};
    vecs[2]  = '{"full_w0_2err",    2'b10, 2'd0, 32'h0000_000B, 32'h0000_00A0, 32'h0000_0001, 2'd2};
    vecs[3]  = '{"dec_w0_clean",    2'b01, 2'd0, 32'h0000_00AA, 32'h0,        32'h0000_000B, 2'd0};
    vecs[4]  = '{"dec_w0_bit0",     2'b01, 2'd0, 32'h0000_00AB, 32'h0,        32'h0000_000B, 2'd1};
    vecs[5]  = '{"enc_w1_1",        2'b00, 2'd1, 32'h0000_0001, 32'h0,        32'h0000_000F, 2'd0};
    vecs[6]  = '{"enc_w0_trunc",    2'b00, 2'd0, 32'h0000_00FB, 32'h0,        32'h0000_00AA, 2'd0};
    vecs[7]  = '{"enc_w2_top",      2'b00, 2'd2, 32'h0200_0000, 32'h0,        32'h8001_0116, 2'd0};
    vecs[8]  = '{"dec_w2_bit20",    2'b01, 2'd2, 32'h8011_0116, 32'h0,        32'h0200_0000, 2'd1};
    vecs[9]  = '{"full_w1_noisemask",2'b10,2'd1, 32'h0000_0001, 32'h0001_0000, 32'h0000_0001, 2'd0};
    vecs[10] = '{"dec_w1_2err",     2'b01, 2'd1, 32'h0000_0009, 32'h0,        32'h0000_0001, 2'd2};
    vecs[11] = '{"dec_w0_highmask", 2'b01, 2'd0, 32'hFFFF_FF8A, 32'h0,        32'h0000_000B, 2'd1};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_err_num", {30'b0, err_num}, 32'h0);
    chk("rst_op_done", {31'b0, operation_done}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    apb_read(20'h10, rd);
    chk("rst_status", rd, 32'h0);
    apb_read(20'h00, rd);
    chk("rst_ctrl", rd, 32'h0);

    // ---- table-driven jobs ----
    for (int v = 0; v < 12; v++) begin
      apb_write(20'h08, {30'b0, vecs[v].w});
      apb_write(20'h04, vecs[v].din);
      apb_write(20'h0C, vecs[v].noise);
      apb_write(20'h00, {29'b0, 1'b1, vecs[v].op});
      wait_done(lat);
      chk({vecs[v].name, "_latency"}, lat, 32'd2);
      chk({vecs[v].name, "_data"}, data_out, vecs[v].exp_data);
      chk({vecs[v].name, "_err"}, {30'b0, err_num}, {30'b0, vecs[v].exp_err});
      apb_read(20'h14, rd);
      exp_result = {vecs[v].exp_err, 4'b0, vecs[v].exp_data[25:0]};
      chk({vecs[v].name, "_result"}, rd, exp_result);
    end
    chk("irq_disabled", {31'b0, irq}, 32'h0);
    chk("data_out_hold", data_out, 32'h0000_000B);

    // ---- config errors ----
    n0 = strobe_cyc.size();
    apb_write(20'h08, 32'h0);
    apb_write(20'h00, 32'h7);
    repeat (4) @(negedge clk);
    chk("cfg_op11_nojob", strobe_cyc.size() - n0, 32'd0);
    apb_read(20'h10, rd);
    chk("cfg_op11_status", rd, 32'h0000_000A);
    apb_write(20'h10, 32'h8);
    apb_write(20'h08, 32'h3);
    apb_write(20'h00, 32'h4);
    repeat (4) @(negedge clk);
    chk("cfg_w3_nojob", strobe_cyc.size() - n0, 32'd0);
    apb_read(20'h10, rd);
    chk("cfg_w3_status", rd, 32'h0000_000A);
    apb_write(20'h10, 32'hA);
    apb_read(20'h10, rd);
    chk("w1c_clear_all", rd, 32'h0);
    apb_write(20'h08, 32'h0);

    // ---- irq ----
    apb_write(20'h04, 32'hB);
    apb_write(20'h0C, 32'h0);
    apb_write(20'h00, 32'hC);
    repeat (4) @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'h1);
    apb_read(20'h00, rd);
    chk("ctrl_readback", rd, 32'h0000_0008);
    apb_write(20'h10, 32'h2);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    apb_read(20'h10, rd);
    chk("done_cleared", rd, 32'h0);

    // ---- W1C of DONE in the same cycle as the hardware set: set wins ----
    apb_write(20'h00, 32'hC);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h10; PWDATA = 32'h2;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    chk("collide_strobe", {31'b0, operation_done}, 32'h1);
    chk("collide_irq", {31'b0, irq}, 32'h1);
    apb_read(20'h10, rd);
    chk("collide_status", rd, 32'h0000_0002);

    // ---- back-to-back START every cycle: 7 accepted, 8th overflows ----
    apb_write(20'h00, 32'h0);
    n0 = strobe_cyc.size();
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h0; PWDATA = 32'h4;
    repeat (8) @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(20'h10, rd);
    chk("burst_status_mid", rd, 32'h0000_0307);
    repeat (20) @(negedge clk);
    chk("burst_strobes", strobe_cyc.size() - n0, 32'd7);
    bad_gap = 0;
    for (int i = n0 + 1; i < strobe_cyc.size(); i++)
      if (strobe_cyc[i] - strobe_cyc[i-1] != 2) bad_gap++;
    chk("burst_gap2", bad_gap, 32'd0);
    apb_read(20'h10, rd);
    chk("burst_status_end", rd, 32'h0000_0006);
    chk("burst_data", data_out, 32'h0000_00AA);
    apb_write(20'h10, 32'h6);

    // ---- reset during CALC ----
    apb_write(20'h00, 32'hC);
    @(negedge clk);
    rst = 1'b0;
    n0 = strobe_cyc.size();
    @(negedge clk);
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_err", {30'b0, err_num}, 32'h0);
    chk("midrst_op_done", {31'b0, operation_done}, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_prdata", PRDATA, 32'h0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_strobe", strobe_cyc.size() - n0, 32'd0);
    apb_read(20'h10, rd);
    chk("midrst_status", rd, 32'h0);
    apb_read(20'h00, rd);
    chk("midrst_ctrl", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
